div_seq: RTL

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 37 +++
 rtl/div_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the default operand width and the controller state encoding.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Shifts {rem,quo} left by one, subtracts the divisor from the shifted
// remainder using ~divisor plus a carry-in of one, and keeps the
// difference when there is no borrow or when a one was shifted out of the
// remainder MSB.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic             shift_out;
  logic [WIDTH-1:0] rem_shift;
  logic [WIDTH-1:0] quo_shift;
  logic [WIDTH:0]   trial;
  logic             take;

  // Shift, trial-subtract and select the next partial remainder/quotient
  always_comb begin
    shift_out = rem_in[WIDTH-1];
    rem_shift = {rem_in[WIDTH-2:0], quo_in[WIDTH-1]};
    quo_shift = {quo_in[WIDTH-2:0], 1'b0};
    trial     = {1'b0, rem_shift} + {1'b0, ~divisor} + {{WIDTH{1'b0}}, 1'b1};
    take      = trial[WIDTH] | shift_out;
    rem_out   = rem_shift;
    quo_out   = quo_shift;
    if (take) begin
      rem_out = trial[WIDTH-1:0];
      quo_out = {quo_shift[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Operands are taken with an in_valid/in_ready handshake in IDLE, WIDTH
// steps run in CALC, and the result is held in DONE until out_ready.
// Compile option: DIV_ZERO_EARLY_EN -- a zero divisor skips CALC and goes
// straight to DONE with the same q/r/dz the full iteration would produce.
module div_seq import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

  div_state_t       state;
  div_state_t       state_next;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] divisor_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dz_q;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             b_zero;

  assign b_zero = (b == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (divisor_q),
    .rem_out (rem_next),
    .quo_out (quo_next)
  );

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef DIV_ZERO_EARLY_EN
          if (b_zero) state_next = DONE;
          else        state_next = CALC;
`else
          state_next = CALC;
`endif
        end
      end
      CALC: begin
        if (cnt_q == '0) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and step counter
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      dz_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            divisor_q <= b;
            dz_q      <= b_zero;
`ifdef DIV_ZERO_EARLY_EN
            if (b_zero) begin
              rem_q <= a;
              quo_q <= '1;
              cnt_q <= '0;
            end else begin
              rem_q <= '0;
              quo_q <= a;
              cnt_q <= CNT_INIT;
            end
`else
            rem_q <= '0;
            quo_q <= a;
            cnt_q <= CNT_INIT;
`endif
          end
        end
        CALC: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign q  = quo_q;
  assign r  = rem_q;
  assign dz = dz_q;

endmodule
